// File: rtl/map_compositor.sv
// map_compositor
//   Full-screen map renderer. A start pulse walks every cell of the selected
//   map in row-major order. For each cell it reads the tile id from map BRAM,
//   replaces it with the tile of the lowest-index entity standing on that
//   cell, and then streams the tile's pixels from tile ROM to the framebuffer.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   start                 frame request (sampled only in IDLE)
//   map_id                map index (latched at start)
//   ent_valid/x/y/tile    entity overlay slots (latched at start)
//   map_addr / map_data   map BRAM read port (1-cycle registered read)
//   tile_addr / tile_data tile ROM read port (1-cycle registered read)
//   dst_addr/data/wr      framebuffer write port (no backpressure)
//   busy                  high in every non-IDLE state
//   done                  one-cycle pulse at frame end
module map_compositor #(
  parameter int MAP_W     = 13,
  parameter int MAP_H     = 13,
  parameter int COORD_W   = 4,
  parameter int TILE      = 32,
  parameter int ID_W      = 10,
  parameter int N_ENT     = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int FB_BASE   = 0,
  parameter int FB_STRIDE = 640
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [7:0]               map_id,
  input  logic [N_ENT-1:0]         ent_valid,
  input  logic [N_ENT*COORD_W-1:0] ent_x,
  input  logic [N_ENT*COORD_W-1:0] ent_y,
  input  logic [N_ENT*ID_W-1:0]    ent_tile,
  output logic [ADDR_W-1:0]        map_addr,
  input  logic [ID_W-1:0]          map_data,
  output logic [ADDR_W-1:0]        tile_addr,
  input  logic [DATA_W-1:0]        tile_data,
  output logic [ADDR_W-1:0]        dst_addr,
  output logic [DATA_W-1:0]        dst_data,
  output logic                     dst_wr,
  output logic                     busy,
  output logic                     done
);

  localparam int PW    = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int TT_SH = 2 * $clog2(TILE);

  localparam logic [ADDR_W-1:0]  CELLS_A    = ADDR_W'(MAP_W * MAP_H);
  localparam logic [ADDR_W-1:0]  FB_BASE_A  = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0]  STRIDE_A   = ADDR_W'(FB_STRIDE);
  localparam logic [ADDR_W-1:0]  TILE_A     = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0]  ROW_STEP_A = ADDR_W'(TILE * FB_STRIDE);
  localparam logic [COORD_W-1:0] GX_LAST    = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] GY_LAST    = COORD_W'(MAP_H - 1);
  localparam logic [PW-1:0]      P_LAST     = PW'(TILE - 1);
  localparam logic [COORD_W:0]   MAP_W_X    = (COORD_W + 1)'(MAP_W);
  localparam logic [COORD_W:0]   MAP_H_X    = (COORD_W + 1)'(MAP_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP_RD,
    S_MAP_WAIT,
    S_PIX,
    S_FLUSH
  } state_t;

  state_t                   state_reg;
  logic [N_ENT-1:0]         ent_valid_reg;
  logic [N_ENT*COORD_W-1:0] ent_x_reg;
  logic [N_ENT*COORD_W-1:0] ent_y_reg;
  logic [N_ENT*ID_W-1:0]    ent_tile_reg;
  logic [COORD_W-1:0]       gx_reg;
  logic [COORD_W-1:0]       gy_reg;
  logic [PW-1:0]            px_reg;
  logic [PW-1:0]            py_reg;
  logic [ADDR_W-1:0]        map_addr_reg;
  logic [ADDR_W-1:0]        tile_addr_reg;
  // Framebuffer address bookkeeping: tgt is the pixel being fetched this
  // PIX cycle, line_base the start of the current pixel row inside the
  // cell, cell_base the top-left pixel of the cell, row_base that of the
  // first cell in the current map row. Everything advances incrementally
  // so no multipliers sit in the pixel loop.
  logic [ADDR_W-1:0]        tgt_reg;
  logic [ADDR_W-1:0]        line_base_reg;
  logic [ADDR_W-1:0]        cell_base_reg;
  logic [ADDR_W-1:0]        row_base_reg;
  logic [ADDR_W-1:0]        dst_addr_reg;
  logic                     dst_wr_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic [N_ENT-1:0]         ent_hit;
  logic [ID_W-1:0]          sel_tile;
  logic [ADDR_W-1:0]        map_base;
  logic [ADDR_W-1:0]        tile_base;
  logic                     px_last;
  logic                     py_last;
  logic                     last_cell;

  // Per-slot hit against the cell currently being rendered. Out-of-range
  // coordinates are rejected explicitly.
  generate
    for (genvar gi = 0; gi < N_ENT; gi++) begin : g_hit
      logic [COORD_W-1:0] ex;
      logic [COORD_W-1:0] ey;
      assign ex = ent_x_reg[gi*COORD_W +: COORD_W];
      assign ey = ent_y_reg[gi*COORD_W +: COORD_W];
      assign ent_hit[gi] = ent_valid_reg[gi]
                        && ({1'b0, ex} < MAP_W_X) && ({1'b0, ey} < MAP_H_X)
                        && (ex == gx_reg) && (ey == gy_reg);
    end
  endgenerate

  // Walk from the highest slot down so the lowest matching index wins.
  always_comb begin
    sel_tile = map_data;
    for (int k = N_ENT - 1; k >= 0; k--) begin
      if (ent_hit[k]) begin
        sel_tile = ent_tile_reg[k*ID_W +: ID_W];
      end
    end
  end

  assign map_base  = ADDR_W'(map_id) * CELLS_A;
  assign tile_base = ADDR_W'(sel_tile) << TT_SH;
  assign px_last   = (px_reg == P_LAST);
  assign py_last   = (py_reg == P_LAST);
  assign last_cell = (gx_reg == GX_LAST) && (gy_reg == GY_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      ent_valid_reg <= '0;
      ent_x_reg     <= '0;
      ent_y_reg     <= '0;
      ent_tile_reg  <= '0;
      gx_reg        <= '0;
      gy_reg        <= '0;
      px_reg        <= '0;
      py_reg        <= '0;
      map_addr_reg  <= '0;
      tile_addr_reg <= '0;
      tgt_reg       <= '0;
      line_base_reg <= '0;
      cell_base_reg <= '0;
      row_base_reg  <= '0;
      dst_addr_reg  <= '0;
      dst_wr_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      // Every PIX cycle yields exactly one write one cycle later, once the
      // tile ROM has returned the pixel.
      dst_wr_reg <= (state_reg == S_PIX);
      if (state_reg == S_PIX) begin
        dst_addr_reg <= tgt_reg;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ent_valid_reg <= ent_valid;
            ent_x_reg     <= ent_x;
            ent_y_reg     <= ent_y;
            ent_tile_reg  <= ent_tile;
            gx_reg        <= '0;
            gy_reg        <= '0;
            px_reg        <= '0;
            py_reg        <= '0;
            map_addr_reg  <= map_base;
            cell_base_reg <= FB_BASE_A;
            row_base_reg  <= FB_BASE_A;
            busy_reg      <= 1'b1;
            state_reg     <= S_MAP_RD;
          end
        end

        S_MAP_RD: begin
          state_reg <= S_MAP_WAIT;
        end

        S_MAP_WAIT: begin
          // map_data is valid now; the chosen tile is captured directly as
          // its ROM base address.
          tile_addr_reg <= tile_base;
          tgt_reg       <= cell_base_reg;
          line_base_reg <= cell_base_reg;
          px_reg        <= '0;
          py_reg        <= '0;
          state_reg     <= S_PIX;
        end

        S_PIX: begin
          if (!px_last) begin
            px_reg        <= px_reg + 1'b1;
            tgt_reg       <= tgt_reg + 1'b1;
            tile_addr_reg <= tile_addr_reg + 1'b1;
          end else if (!py_last) begin
            px_reg        <= '0;
            py_reg        <= py_reg + 1'b1;
            line_base_reg <= line_base_reg + STRIDE_A;
            tgt_reg       <= line_base_reg + STRIDE_A;
            tile_addr_reg <= tile_addr_reg + 1'b1;
          end else begin
            // Last pixel of the cell.
            px_reg <= '0;
            py_reg <= '0;
            if (last_cell) begin
              state_reg <= S_FLUSH;
            end else begin
              // Map cells are row-major, so the next cell is the next word.
              map_addr_reg <= map_addr_reg + 1'b1;
              state_reg    <= S_MAP_RD;
              if (gx_reg == GX_LAST) begin
                gx_reg        <= '0;
                gy_reg        <= gy_reg + 1'b1;
                row_base_reg  <= row_base_reg + ROW_STEP_A;
                cell_base_reg <= row_base_reg + ROW_STEP_A;
              end else begin
                gx_reg        <= gx_reg + 1'b1;
                cell_base_reg <= cell_base_reg + TILE_A;
              end
            end
          end
        end

        S_FLUSH: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign map_addr  = map_addr_reg;
  assign tile_addr = tile_addr_reg;
  assign dst_addr  = dst_addr_reg;
  // The ROM output is the pixel; gating keeps the port at zero between writes.
  assign dst_data  = dst_wr_reg ? tile_data : '0;
  assign dst_wr    = dst_wr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_map_compositor.sv
// tb_map_compositor
//   Bench for map_compositor with a 2x2 map of 2x2 tiles, FB_BASE=100,
//   FB_STRIDE=640. Map BRAM and tile ROM (word = address) are modelled here.
//   Expected framebuffer writes are pushed to exp_q when a frame is started
//   and compared in order against the writes collected in obs_q.
module tb_map_compositor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  map_id;
  logic [3:0]  ent_valid;
  logic [15:0] ent_x;
  logic [15:0] ent_y;
  logic [39:0] ent_tile;
  logic [18:0] map_addr;
  logic [9:0]  map_data;
  logic [18:0] tile_addr;
  logic [15:0] tile_data;
  logic [18:0] dst_addr;
  logic [15:0] dst_data;
  logic        dst_wr;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0]  map_mem [0:1023];
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];

  map_compositor #(
    .MAP_W(2), .MAP_H(2), .COORD_W(4), .TILE(2), .ID_W(10), .N_ENT(4),
    .ADDR_W(19), .DATA_W(16), .FB_BASE(100), .FB_STRIDE(640)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .map_id(map_id),
    .ent_valid(ent_valid), .ent_x(ent_x), .ent_y(ent_y), .ent_tile(ent_tile),
    .map_addr(map_addr), .map_data(map_data),
    .tile_addr(tile_addr), .tile_data(tile_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_wr(dst_wr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory models with 1-cycle registered read.
  always @(posedge clk) begin
    map_data  <= map_mem[map_addr[9:0]];
    tile_data <= tile_addr[15:0];
  end

  // Write collector.
  always @(negedge clk) begin
    if (dst_wr === 1'b1) obs_q.push_back({dst_addr, dst_data});
  end

  // Reference frame: direct per-cell / per-pixel address formulae.
  task automatic push_frame(input logic [7:0] mid, input logic [3:0] v,
                            input logic [15:0] xs, input logic [15:0] ys,
                            input logic [39:0] ts);
    logic [9:0] t;
    for (int gy = 0; gy < 2; gy++) begin
      for (int gx = 0; gx < 2; gx++) begin
        t = map_mem[int'(mid) * 4 + gy * 2 + gx];
        for (int k = 3; k >= 0; k--) begin
          if (v[k] && int'(xs[k*4 +: 4]) == gx && int'(ys[k*4 +: 4]) == gy)
            t = ts[k*10 +: 10];
        end
        for (int py = 0; py < 2; py++)
          for (int px = 0; px < 2; px++)
            exp_q.push_back({19'(100 + (gy * 2 + py) * 640 + gx * 2 + px),
                             16'(int'(t) * 4 + py * 2 + px)});
      end
    end
  endtask

  // Issue a one-cycle start and return the cycle number of done (-1 on timeout).
  task automatic wait_done(input int budget, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; map_id = 8'd0;
    ent_valid = '0; ent_x = '0; ent_y = '0; ent_tile = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, done, dst_wr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, dst_wr}); end
    n_checks++; if (map_addr !== 19'd0) begin n_fail++; $display("FAIL reset_map_addr: got %0d expected 0", map_addr); end
    n_checks++; if (tile_addr !== 19'd0) begin n_fail++; $display("FAIL reset_tile_addr: got %0d expected 0", tile_addr); end
    n_checks++; if (dst_addr !== 19'd0) begin n_fail++; $display("FAIL reset_dst_addr: got %0d expected 0", dst_addr); end
    n_checks++; if (dst_data !== 16'd0) begin n_fail++; $display("FAIL reset_dst_data: got %0d expected 0", dst_data); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, dst_wr} !== 3'b000) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, dst_wr}); end
  endtask

  task automatic test_basic;
    logic        exp_busy, exp_done, exp_wr;
    logic [18:0] exp_ma;
    logic [34:0] e, o;
    map_id = 8'd1; ent_valid = 4'b0000;
    exp_q.delete(); obs_q.delete();
    push_frame(8'd1, 4'b0000, ent_x, ent_y, ent_tile);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      exp_busy = (c <= 25);
      exp_done = (c == 26);
      exp_wr   = (c >= 4) && (c <= 25) && (((c - 1) % 6 == 0) || ((c - 1) % 6 >= 3));
      n_checks++;
      if ({busy, done, dst_wr} !== {exp_busy, exp_done, exp_wr}) begin
        n_fail++; $display("FAIL basic_timing cycle %0d: busy/done/wr got %b expected %b", c, {busy, done, dst_wr}, {exp_busy, exp_done, exp_wr});
      end
      if (c == 1 || c == 7 || c == 13 || c == 19) begin
        exp_ma = 19'(4 + (c - 1) / 6);
        n_checks++;
        if (map_addr !== exp_ma) begin n_fail++; $display("FAIL basic_map_addr cycle %0d: got %0d expected %0d", c, map_addr, exp_ma); end
      end
    end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL basic_write: got addr=%0d data=%0d expected addr=%0d data=%0d", o[34:16], o[15:0], e[34:16], e[15:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_priority;
    int          dc;
    logic [34:0] e, o;
    map_id   = 8'd1;
    // slot0 (1,0) tile 9; slot1 x out of range; slot2 (1,0) tile 3; slot3 y out of range
    ent_x    = {4'd0, 4'd1, 4'd2, 4'd1};
    ent_y    = {4'd3, 4'd0, 4'd0, 4'd0};
    ent_tile = {10'd60, 10'd3, 10'd50, 10'd9};
    for (int pass = 0; pass < 2; pass++) begin
      ent_valid = (pass == 0) ? 4'b1111 : 4'b1110;
      exp_q.delete(); obs_q.delete();
      push_frame(map_id, ent_valid, ent_x, ent_y, ent_tile);
      wait_done(40, dc);
      n_checks++; if (dc != 26) begin n_fail++; $display("FAIL prio_done_cycle pass %0d: got %0d expected 26", pass, dc); end
      n_checks++;
      if (obs_q.size() != 16) begin
        n_fail++; $display("FAIL prio_write_count pass %0d: got %0d expected 16", pass, obs_q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (obs_q[4 + i][15:0] !== 16'(((pass == 0) ? 36 : 12) + i)) begin
            n_fail++; $display("FAIL prio_cell10_pixel%0d pass %0d: got %0d expected %0d", i, pass, obs_q[4 + i][15:0], ((pass == 0) ? 36 : 12) + i);
          end
        end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
        if (o !== e) begin n_fail++; $display("FAIL prio_write: got addr=%0d data=%0d expected addr=%0d data=%0d", o[34:16], o[15:0], e[34:16], e[15:0]); end
      end
    end
    exp_q.delete(); obs_q.delete();
    ent_valid = 4'b0000;
  endtask

  task automatic test_addressing;
    int dc;
    map_id = 8'd1; ent_valid = 4'b0000;
    exp_q.delete(); obs_q.delete();
    wait_done(40, dc);
    n_checks++; if (dc != 26) begin n_fail++; $display("FAIL addr_done_cycle: got %0d expected 26", dc); end
    n_checks++;
    if (obs_q.size() != 16) begin
      n_fail++; $display("FAIL addr_write_count: got %0d expected 16", obs_q.size());
    end else begin
      n_checks++; if (obs_q[12][34:16] !== 19'd1382) begin n_fail++; $display("FAIL addr_cell11_first: got %0d expected 1382", obs_q[12][34:16]); end
      n_checks++; if (obs_q[15][34:16] !== 19'd2023) begin n_fail++; $display("FAIL addr_cell11_px11: got %0d expected 2023", obs_q[15][34:16]); end
      n_checks++; if (obs_q[0][34:16] !== 19'd100) begin n_fail++; $display("FAIL addr_first_write: got %0d expected 100", obs_q[0][34:16]); end
    end
    obs_q.delete();
  endtask

  task automatic test_snapshot;
    int          n_done, first_done;
    logic [34:0] e, o;
    map_id = 8'd1; ent_valid = 4'b0000; ent_x = '0; ent_y = '0;
    exp_q.delete(); obs_q.delete();
    push_frame(8'd1, 4'b0000, ent_x, ent_y, ent_tile);
    n_done = 0; first_done = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        map_id = 8'd2; ent_valid = 4'b1111; ent_x = 16'h1010; ent_y = 16'h0101; start = 1'b1;
      end
      if (c == 6) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    n_checks++; if (first_done != 26) begin n_fail++; $display("FAIL snap_done_cycle: got %0d expected 26", first_done); end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL snap_done_count: got %0d expected 1", n_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL snap_idle_after: got busy=%b expected 0", busy); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL snap_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL snap_write: got addr=%0d data=%0d expected addr=%0d data=%0d", o[34:16], o[15:0], e[34:16], e[15:0]); end
    end
    exp_q.delete(); obs_q.delete();
    map_id = 8'd1; ent_valid = 4'b0000;
  endtask

  task automatic test_back_to_back;
    int          d1, d2;
    logic        busy27;
    logic [18:0] ma27;
    logic [34:0] e, o;
    map_id = 8'd1; ent_valid = 4'b0000;
    exp_q.delete(); obs_q.delete();
    push_frame(8'd1, 4'b0000, ent_x, ent_y, ent_tile);
    push_frame(8'd1, 4'b0000, ent_x, ent_y, ent_tile);
    d1 = -1; d2 = -1; busy27 = 1'b0; ma27 = '0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 27) begin busy27 = busy; ma27 = map_addr; end
      if (done === 1'b1) begin
        if (d1 < 0) d1 = c;
        else begin d2 = c; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    n_checks++; if (d1 != 26) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 26", d1); end
    n_checks++; if (d2 != 52) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected 52", d2); end
    n_checks++; if ({busy27, ma27} !== {1'b1, 19'd4}) begin n_fail++; $display("FAIL b2b_second_map_rd: got busy=%b map_addr=%0d expected busy=1 map_addr=4", busy27, ma27); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stops: got busy=%b expected 0", busy); end
    n_checks++; if (obs_q.size() != 32) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_write: got addr=%0d data=%0d expected addr=%0d data=%0d", o[34:16], o[15:0], e[34:16], e[15:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_midframe_reset;
    int          saw_done, dc;
    logic [34:0] e, o;
    map_id = 8'd1; ent_valid = 4'b0000;
    saw_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done === 1'b1) saw_done++;
    end
    rstn = 1'b0;
    #1;
    n_checks++; if ({busy, done, dst_wr} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", {busy, done, dst_wr}); end
    n_checks++; if ({map_addr, tile_addr, dst_addr, dst_data} !== 73'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got map=%0d tile=%0d dst=%0d data=%0d expected all 0", map_addr, tile_addr, dst_addr, dst_data); end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    rstn = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    n_checks++; if (saw_done != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", saw_done); end
    // Fresh frame with one overlay at (0,1).
    ent_valid = 4'b0001; ent_x = 16'h0000; ent_y = 16'h0001; ent_tile = {30'd0, 10'd7};
    exp_q.delete(); obs_q.delete();
    push_frame(map_id, ent_valid, ent_x, ent_y, ent_tile);
    wait_done(40, dc);
    n_checks++; if (dc != 26) begin n_fail++; $display("FAIL rst_fresh_done: got %0d expected 26", dc); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_fresh_write_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rst_fresh_write: got addr=%0d data=%0d expected addr=%0d data=%0d", o[34:16], o[15:0], e[34:16], e[15:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) map_mem[i] = 10'((i * 7 + 3) % 1024);
    map_mem[4] = 10'd5; map_mem[5] = 10'd6; map_mem[6] = 10'd7; map_mem[7] = 10'd8;
    test_reset();
    test_basic();
    test_priority();
    test_addressing();
    test_snapshot();
    test_back_to_back();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
